seg_scan_driver: RTL
====================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles each digit is lit (SHOW time); legal range >= 2.
REQ-002 Parameter GAP_CYCLES, default 16, cycles with all anodes off between digits (anti-ghosting); legal range >= 0.
REQ-003 clk  in  1  system clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 value  in  16  four hex nibbles; digit k = value[4k+3:4k].
REQ-006 dp_in  in  4  decimal point request per digit, 1 = lit.
REQ-007 blank  in  4  per-digit blank request, 1 = digit dark.
REQ-008 load  in  1  capture strobe for value/dp_in/blank.
REQ-009 seg  out  7  segments a..g on bits 0..6, active-low.
REQ-010 dp  out  1  decimal point, active-low.
REQ-011 an  out  4  digit anodes, active-low; an[k] selects digit k.
REQ-012 frame_tick  out  1  one-cycle pulse when scan wraps digit 3 -> 0.

Function
REQ-013 load high at a rising edge SHALL copy value, dp_in, blank into shadow registers; display uses only shadow registers.
REQ-014 load SHALL NOT disturb the scan counter, digit index or FSM state.
REQ-015 FSM states SHOW and GAP; SHOW lasts exactly REFRESH_DIV cycles, GAP exactly GAP_CYCLES cycles.
REQ-016 SHOW end: digit index increments mod 4; next state GAP, or SHOW directly when GAP_CYCLES = 0.
REQ-017 GAP end: next state SHOW with the already-advanced digit index.
REQ-018 Scan order SHALL be 0,1,2,3,0,...; one full frame = 4*(REFRESH_DIV+GAP_CYCLES) cycles.
REQ-019 Outputs SHALL be registered: pins reflect FSM state/index/shadow of the previous cycle (1-cycle latency).
REQ-020 In SHOW for digit k: an = only bit k low; seg = hex glyph of shadow nibble k; dp = ~shadow_dp[k].
REQ-021 Blanked digit (shadow_blank[k]=1) in SHOW: an bit k still low, seg = 7'b1111111, dp = 1.
REQ-022 In GAP: an = 4'b1111, seg = 7'b1111111, dp = 1.
REQ-023 Glyphs 0-F SHALL use standard hex shapes (0=7'b1000000, 1=7'b1111001, 8=7'b0000000, A=7'b0001000, F=7'b0001110).
REQ-024 load coinciding with a digit change SHALL make the new digit display the newly loaded data.
REQ-025 frame_tick SHALL pulse for one cycle, aligned with the registered an output first selecting digit 0 after digit 3.

Reset
REQ-026 rst_n low SHALL immediately force seg=7'b1111111, dp=1, an=4'b1111, frame_tick=0.
REQ-027 Reset SHALL set state SHOW, digit index 0, counter 0, shadow value 0, shadow dp 0, shadow blank 4'b1111 (dark until first load).
REQ-028 Reset mid-frame SHALL discard scan position; after release, scan restarts at digit 0 with full REFRESH_DIV dwell.

Configuration
REQ-029 Macro SEG_LZ_BLANK_EN defined: digits 3..1 SHALL auto-blank while their nibble and all higher nibbles are zero; digit 0 never auto-blanked; dp unaffected; OR'd with shadow_blank.
REQ-030 Macro undefined: no leading-zero blanking; only shadow_blank darkens digits.

Structure
REQ-031 Shared package seg_pkg SHALL hold the FSM state enum, SEG_OFF (7'b1111111) and AN_OFF (4'b1111) constants, and the 16-entry glyph table.
REQ-032 Sub-module hex_to_seg (4-bit nibble in, 7-bit active-low glyph out, combinational) SHALL perform glyph lookup.

Verification (REFRESH_DIV=4, GAP_CYCLES=2)
REQ-033 Reset release, no load -> an cycles 1110/1111/1101/..., seg stays 7'b1111111, dp stays 1.
REQ-034 load value=16'h12AF, blank=0, dp_in=4'b0100 -> digit0 seg=7'b0001110, digit1 7'b0001000, digit2 7'b0100100 with dp=0, digit3 7'b1111001; each 4 cycles, 2-cycle GAP between.
REQ-035 frame_tick period = 24 cycles; exactly one cycle high per frame.
REQ-036 GAP_CYCLES=0 build: load 16'h8888 -> an changes directly 1110->1101, seg constant 7'b0000000, no all-off cycles.
REQ-037 SEG_LZ_BLANK_EN, load 16'h0007 -> digits 3..1 dark, digit 0 = 7'b1111000; load 16'h0000 -> digit 0 shows 7'b1000000.
REQ-038 Assert rst_n low during digit 2 SHOW -> outputs off same cycle; after release, digit 0 lit for full 4 cycles, shadow blank=4'b1111.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan driver: scan FSM states,
// all-off output constants and the active-low hex glyph table (bit 0 = a .. bit 6 = g).
package seg_pkg;

    typedef enum logic {
        SHOW = 1'b0,
        GAP  = 1'b1
    } scanState_e;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Indexed by nibble value; entry 15 is listed first in the concatenation.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/seg_scan_driver_if.sv
// Host-facing bus of the scan driver: display data and its capture strobe,
// plus the registered segment/anode pins and the frame marker.
interface seg_scan_driver_if;

    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic        load;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    modport master (
        output value, dp_in, blank, load,
        input  seg, dp, an, frame_tick
    );

    modport slave (
        input  value, dp_in, blank, load,
        output seg, dp, an, frame_tick
    );

endinterface

// File: rtl/seg_scan_driver_hex_to_seg.sv
// Combinational nibble-to-glyph lookup, active-low segments a..g on bits 0..6.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    assign glyph = GLYPH_TABLE[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver. Each digit is lit for
// REFRESH_DIV cycles, followed by GAP_CYCLES of all-anodes-off to stop ghosting.
// Build option SEG_LZ_BLANK_EN darkens leading-zero digits 3..1.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GAP_CYCLES  = 16
) (
    input logic            clk,
    input logic            rst_n,
    seg_scan_driver_if.slave bus
);

    localparam int CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = (GAP_CYCLES == 0) ? '0 : CW'(GAP_CYCLES - 1);

    scanState_e    state, stateNext;
    logic [CW-1:0] cnt, cntNext;
    logic [1:0]    digitIdx, digitIdxNext;
    logic          wrapPending, wrapPendingNext;

    logic [15:0] shadowValue;
    logic [3:0]  shadowDp;
    logic [3:0]  shadowBlank;

    logic [3:0] autoBlank;
    logic [3:0] curNibble;
    logic [6:0] curGlyph;
    logic       segDark;

    logic [6:0] segQ;
    logic       dpQ;
    logic [3:0] anQ;
    logic       tickQ;

    // Scan state register: FSM state, dwell counter, digit index, wrap marker.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state       <= SHOW;
            cnt         <= '0;
            digitIdx    <= 2'd0;
            wrapPending <= 1'b0;
        end else begin
            state       <= stateNext;
            cnt         <= cntNext;
            digitIdx    <= digitIdxNext;
            wrapPending <= wrapPendingNext;
        end
    end

    // Next-state logic: count dwell, advance digit at end of SHOW, return from GAP.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        stateNext       = state;
        cntNext         = cnt + CW'(1);
        digitIdxNext    = digitIdx;
        wrapPendingNext = wrapPending;
        // The wrap marker is consumed when digit 0 starts its dwell.
        if (state == SHOW && cnt == '0 && digitIdx == 2'd0)
            wrapPendingNext = 1'b0;
        case (state)
            SHOW: begin
                if (cnt == SHOW_LAST) begin
                    cntNext      = '0;
                    digitIdxNext = digitIdx + 2'd1;
                    if (digitIdx == 2'd3)
                        wrapPendingNext = 1'b1;
                    stateNext = (GAP_CYCLES == 0) ? SHOW : GAP;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cntNext   = '0;
                    stateNext = SHOW;
                end
            end
            default: stateNext = SHOW;
        endcase
    end

    // Shadow capture: display data changes only on load, never touching the scan.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: shadow blank resets to all-ones so the display stays dark until first load.
        if (!rst_n) begin
            shadowValue <= 16'h0000;
            shadowDp    <= 4'b0000;
            shadowBlank <= 4'b1111;
        end else if (bus.load) begin
            shadowValue <= bus.value;
            shadowDp    <= bus.dp_in;
            shadowBlank <= bus.blank;
        end
    end

`ifdef SEG_LZ_BLANK_EN
    assign autoBlank = {shadowValue[15:12] == 4'h0,
                        shadowValue[15:8]  == 8'h00,
                        shadowValue[15:4]  == 12'h000,
                        1'b0};
`else
    assign autoBlank = 4'b0000;
`endif

    assign curNibble = shadowValue[{digitIdx, 2'b00} +: 4];
    assign segDark   = shadowBlank[digitIdx] | autoBlank[digitIdx];

    hex_to_seg uGlyph (
        .nibble (curNibble),
        .glyph  (curGlyph)
    );

    // Output pin registers: one cycle behind the scan state and shadow data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segQ  <= SEG_OFF;
            dpQ   <= 1'b1;
            anQ   <= AN_OFF;
            tickQ <= 1'b0;
        end else begin
            if (state == SHOW) begin
                anQ  <= ~(4'b0001 << digitIdx);
                segQ <= segDark ? SEG_OFF : curGlyph;
                dpQ  <= shadowBlank[digitIdx] ? 1'b1 : ~shadowDp[digitIdx];
            end else begin
                anQ  <= AN_OFF;
                segQ <= SEG_OFF;
                dpQ  <= 1'b1;
            end
            tickQ <= wrapPending && (state == SHOW) && (cnt == '0) && (digitIdx == 2'd0);
        end
    end

    assign bus.seg        = segQ;
    assign bus.dp         = dpQ;
    assign bus.an         = anQ;
    assign bus.frame_tick = tickQ;

endmodule
